// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 16-bit core: owns the PC, issues imem reads,
// and drives the IF/ID pipeline register (stall, flush, redirect and HLT handling).
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus2,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [15:0] redir_q, redir_d;
  logic [15:0] hold_q, hold_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] ifpc2_q, ifpc2_d;
  logic        halted_q;
  logic [15:0] target_s;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  assign target_s       = {branch_target[15:1], 1'b0};
  // Request is gated by reset so it is low during the reset cycle itself.
  assign imem_req       = rst_n & (state_q == ST_FETCH);
  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus2 = ifpc2_q;
  assign halted         = halted_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    redir_d  = redir_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    ifpc2_d  = ifpc2_q;
    case (state_q)
      ST_FETCH: begin
        if (!imem_ready) begin
          if (branch_taken) begin
            // Redirect is deferred until the outstanding response retires.
            redir_d  = target_s;
            squash_d = 1'b1;
            valid_d  = 1'b0;
            instr_d  = NOP_INSTR;
          end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else begin
            valid_d = valid_q;
          end
        end else if (squash_q || branch_taken) begin
          pc_d     = squash_q ? redir_q : target_s;
          squash_d = 1'b0;
          valid_d  = 1'b0;
          instr_d  = NOP_INSTR;
        end else if (stall) begin
          hold_d  = imem_rdata;
          state_d = ST_HOLD;
        end else begin
          valid_d = 1'b1;
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          ifpc2_d = pc_inc(pc_q);
          pc_d    = pc_inc(pc_q);
          if (imem_rdata[15:12] == HALT_OP) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_d    = target_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = ST_FETCH;
        end else if (!stall) begin
          valid_d = 1'b1;
          instr_d = hold_q;
          ifpc_d  = pc_q;
          ifpc2_d = pc_inc(pc_q);
          pc_d    = pc_inc(pc_q);
          if (hold_q[15:12] == HALT_OP) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        if (branch_taken) begin
          pc_d    = target_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = ST_FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_FETCH;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      redir_q  <= 16'h0000;
      hold_q   <= 16'h0000;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      ifpc_q   <= 16'h0000;
      ifpc2_q  <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      redir_q  <= redir_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      ifpc2_q  <= ifpc2_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for multi-cycle
// corners, and random stimulus checked against a behavioural fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
  logic [15:0] branch_target = 16'h0000, imem_rdata = 16'h0000;
  logic        imem_req, if_id_valid, halted;
  logic [15:0] imem_addr, if_id_instr, if_id_pc, if_id_pc_plus2;
  logic        h_imem_req, h_if_id_valid, h_halted;
  logic [15:0] h_imem_addr, h_if_id_instr, h_if_id_pc, h_if_id_pc_plus2;
  int          n_chk = 0, n_fail = 0;
  bit          m_on = 1'b0;

  // Behavioural model of the default-parameter instance.
  logic [15:0] m_pc = 16'h0000, m_redir = 16'h0000, m_buf_i = 16'h0000;
  logic [15:0] m_i = 16'h0000, m_p = 16'h0000;
  logic        m_squash = 1'b0, m_buf = 1'b0, m_stop = 1'b0, m_v = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus2(if_id_pc_plus2),
    .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut6 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(h_imem_req), .imem_addr(h_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_valid(h_if_id_valid),
    .if_id_instr(h_if_id_instr), .if_id_pc(h_if_id_pc), .if_id_pc_plus2(h_if_id_pc_plus2),
    .halted(h_halted)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic [15:0] dat;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_i;
    logic [15:0] e_pc;
    logic        e_h;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit six, input logic e_req,
                         input logic [15:0] e_addr, input logic e_v, input logic [15:0] e_i,
                         input logic [15:0] e_pc, input logic e_h);
    logic        a_req, a_v, a_h;
    logic [15:0] a_addr, a_i, a_pc, a_pc2;
    a_req  = six ? h_imem_req       : imem_req;
    a_addr = six ? h_imem_addr      : imem_addr;
    a_v    = six ? h_if_id_valid    : if_id_valid;
    a_i    = six ? h_if_id_instr    : if_id_instr;
    a_pc   = six ? h_if_id_pc       : if_id_pc;
    a_pc2  = six ? h_if_id_pc_plus2 : if_id_pc_plus2;
    a_h    = six ? h_halted         : halted;
    chk({tag, ".req"}, {15'h0000, a_req}, {15'h0000, e_req});
    if (e_req) chk({tag, ".addr"}, a_addr, e_addr);
    chk({tag, ".valid"}, {15'h0000, a_v}, {15'h0000, e_v});
    chk({tag, ".instr"}, a_i, e_i);
    if (e_v) begin
      chk({tag, ".pc"}, a_pc, e_pc);
      chk({tag, ".pc_plus2"}, a_pc2, e_pc + 16'd2);
    end
    chk({tag, ".halted"}, {15'h0000, a_h}, {15'h0000, e_h});
  endtask

  task automatic deliver(input logic [15:0] w);
    m_v  = 1'b1;
    m_i  = w;
    m_p  = m_pc;
    m_pc = m_pc + 16'd2;
    if (w[15:12] == 4'hF) m_stop = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_step();
    logic [15:0] t;
    t = branch_target & 16'hFFFE;
    if (!rst_n) begin
      m_pc = 16'h0000; m_squash = 1'b0; m_buf = 1'b0; m_stop = 1'b0;
      m_v = 1'b0; m_i = 16'h0000; m_p = 16'h0000;
    end else if (m_stop) begin
      if (branch_taken) begin m_pc = t; m_stop = 1'b0; m_v = 1'b0; m_i = 16'h0000; end
      else if (!stall) begin m_v = 1'b0; m_i = 16'h0000; end
    end else if (m_buf) begin
      if (branch_taken) begin m_pc = t; m_buf = 1'b0; m_v = 1'b0; m_i = 16'h0000; end
      else if (!stall) begin m_buf = 1'b0; deliver(m_buf_i); end
    end else if (!imem_ready) begin
      if (branch_taken) begin m_redir = t; m_squash = 1'b1; m_v = 1'b0; m_i = 16'h0000; end
      else if (!stall) begin m_v = 1'b0; m_i = 16'h0000; end
    end else if (m_squash || branch_taken) begin
      m_pc = m_squash ? m_redir : t;
      m_squash = 1'b0; m_v = 1'b0; m_i = 16'h0000;
    end else if (stall) begin
      m_buf = 1'b1; m_buf_i = imem_rdata;
    end else begin
      deliver(imem_rdata);
    end
  endtask

  task automatic apply(input logic r, input logic st, input logic br, input logic [15:0] tgt,
                       input logic rdy, input logic [15:0] dat);
    rst_n = r; stall = st; branch_taken = br; branch_target = tgt;
    imem_ready = rdy; imem_rdata = dat;
    #3;
    if (m_on) chk_out("model", 1'b0, rst_n && !m_buf && !m_stop, m_pc, m_v, m_i, m_p, m_stop);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    //            rst   st    br    tgt       rdy   dat       req   addr      v     instr     pc        h
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0004, 1'b1, 16'h1234, 16'h0002, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h0006, 1'b1, 16'h1234, 16'h0004, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 16'h0041, 1'b1, 16'h1234, 1'b1, 16'h0008, 1'b1, 16'h1234, 16'h0006, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h9ABC, 1'b1, 16'h0042, 1'b1, 16'h5678, 16'h0040, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 16'h0044, 1'b1, 16'h9ABC, 16'h0042, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h9ABC, 16'h0042, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h9ABC, 16'h0042, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h9ABC, 16'h0042, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'h0046, 1'b1, 16'h1111, 16'h0044, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 16'h0048, 1'b1, 16'h2222, 16'h0046, 1'b0};

    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk("reset_cycle.req", {15'h0000, imem_req}, 16'h0000);
    tick();
    m_on = 1'b1;

    // Streaming, same-cycle branch+stall, and stall/HOLD release.
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].dat);
      chk_out($sformatf("vec%0d", i), 1'b0, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v,
              tbl[i].e_i, tbl[i].e_pc, tbl[i].e_h);
      if (i == 0) begin
        chk("reset.if_id_pc", if_id_pc, 16'h0000);
        chk("reset.if_id_pc_plus2", if_id_pc_plus2, 16'h0000);
      end
      tick();
    end

    // Redirect during a long imem wait.
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0202); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk_out("wait1", 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0202, 16'h0002, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
    chk_out("wait2", 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk_out("wait3", 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0404);
    chk_out("wait_resp", 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0505);
    chk_out("redir_addr", 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    chk_out("redir_first", 1'b0, 1'b1, 16'h0102, 1'b1, 16'h0505, 16'h0100, 1'b0); tick();

    // HLT at 0x000A, then a resuming branch.
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000); tick();
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000); tick();
    end
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000);
    chk_out("pre_hlt", 1'b0, 1'b1, 16'h000A, 1'b1, 16'h0000, 16'h0008, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk_out("hlt_show", 1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h000A, 1'b1); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk_out("hlt_bubble", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1); tick();
    apply(1'b1, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h1234);
    chk_out("hlt_branch", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
    chk_out("resume", 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
    chk_out("resume2", 1'b0, 1'b1, 16'h0022, 1'b1, 16'h7777, 16'h0020, 1'b0); tick();

    // PC wrap with RESET_PC = 0xFFFE, and reset in the middle of a wait.
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    chk_out("wrap_first", 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk_out("wrap_second", 1'b1, 1'b1, 16'h0000, 1'b1, 16'h1234, 16'hFFFE, 1'b0);
    chk("wrap.pc_plus2", h_if_id_pc_plus2, 16'h0000); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("midwait_rst.req", {15'h0000, h_imem_req}, 16'h0000); tick();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk_out("midwait_restart", 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0); tick();

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 2) != 0),
            16'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
